// File: rtl/baud_tick_gen.sv
// Baud-rate tick generator: programmable integer/fractional divisor,
// oversample tick, baud tick and shadowed divisor load.
module baud_tick_gen #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVERSAMPLE   = 16,
  parameter int OS_W         = 4,
  parameter int DEF_DIV_INT  = 10,
  parameter int DEF_DIV_FRAC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              div_err,
  output logic              sample_tick,
  output logic              baud_tick,
  output logic [CNT_W-1:0]  q_out,
  output logic [OS_W-1:0]   os_cnt,
  output logic              div_pending
);

  localparam logic [CNT_W-1:0]  DefInt  = CNT_W'(DEF_DIV_INT);
  localparam logic [FRAC_W-1:0] DefFrac = FRAC_W'(DEF_DIV_FRAC);
  localparam logic [OS_W-1:0]   OsLast  = OS_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0]  MinDiv  = CNT_W'(2);

  logic [CNT_W-1:0]  q_q, q_d;
  logic [OS_W-1:0]   os_q, os_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  int_q, int_d;
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [CNT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;
  logic              baud_q, baud_d;
  logic              err_q, err_d;

  logic [FRAC_W:0]   sum;
  logic [CNT_W:0]    per;
  logic [CNT_W:0]    per_m1;
  logic              wrap;
  logic              apply;
  logic              load_ok;
  logic              load_bad;

  // Dither: the accumulator carry stretches the period by one clock.
  assign sum    = {1'b0, acc_q} + {1'b0, frac_q};
  assign per    = {1'b0, int_q} + (CNT_W+1)'(sum[FRAC_W]);
  assign per_m1 = per - 1'b1;

  // >= keeps a divisor shrunk during freeze from overrunning the count.
  assign wrap     = en && ({1'b0, q_q} >= per_m1);
  assign apply    = pend_q && (!en || wrap);
  assign load_ok  = div_load && (div_int >= MinDiv);
  assign load_bad = div_load && (div_int < MinDiv);

  always_comb begin
    q_d       = q_q;
    os_d      = os_q;
    acc_d     = acc_q;
    int_d     = int_q;
    frac_d    = frac_q;
    sh_int_d  = sh_int_q;
    sh_frac_d = sh_frac_q;
    pend_d    = pend_q;
    tick_d    = 1'b0;
    baud_d    = 1'b0;
    err_d     = load_bad;
    if (en) begin
      if (wrap) begin
        q_d    = '0;
        acc_d  = sum[FRAC_W-1:0];
        os_d   = (os_q == OsLast) ? '0 : os_q + 1'b1;
        tick_d = 1'b1;
        baud_d = (os_q == OsLast);
      end else begin
        q_d = q_q + 1'b1;
      end
    end
    if (apply) begin
      int_d  = sh_int_q;
      frac_d = sh_frac_q;
      pend_d = 1'b0;
    end
    if (load_ok) begin
      sh_int_d  = div_int;
      sh_frac_d = div_frac;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q       <= '0;
      os_q      <= '0;
      acc_q     <= '0;
      int_q     <= DefInt;
      frac_q    <= DefFrac;
      sh_int_q  <= DefInt;
      sh_frac_q <= DefFrac;
      pend_q    <= 1'b0;
      tick_q    <= 1'b0;
      baud_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      os_q      <= os_d;
      acc_q     <= acc_d;
      int_q     <= int_d;
      frac_q    <= frac_d;
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      baud_q    <= baud_d;
      err_q     <= err_d;
    end
  end

  assign q_out       = q_q;
  assign os_cnt      = os_q;
  assign sample_tick = tick_q;
  assign baud_tick   = baud_q;
  assign div_err     = err_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: directed scenarios plus random traffic,
// all checked against an arithmetic period model.
module tb_baud_tick_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        div_load = 1'b0;
  logic        div_err;
  logic        sample_tick;
  logic        baud_tick;
  logic [15:0] q_out;
  logic [3:0]  os_cnt;
  logic        div_pending;

  baud_tick_gen dut (
    .clk(clk),
    .reset_n(reset_n),
    .en(en),
    .div_int(div_int),
    .div_frac(div_frac),
    .div_load(div_load),
    .div_err(div_err),
    .sample_tick(sample_tick),
    .baud_tick(baud_tick),
    .q_out(q_out),
    .os_cnt(os_cnt),
    .div_pending(div_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: phase within period, periods from floor((acc+frac)/16).
  int m_q = 0, m_os = 0, m_acc = 0;
  int m_int = 10, m_frac = 0, m_sint = 10, m_sfrac = 0;
  bit m_pend = 0, m_tick = 0, m_baud = 0, m_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    int per;
    bit wrap;
    if (!reset_n) begin
      m_q = 0; m_os = 0; m_acc = 0;
      m_int = 10; m_frac = 0; m_sint = 10; m_sfrac = 0;
      m_pend = 0; m_tick = 0; m_baud = 0; m_err = 0;
    end else begin
      per = m_int + (m_acc + m_frac) / 16;
      wrap = en && (m_q >= per - 1);
      m_err = div_load && (div_int < 2);
      m_tick = wrap;
      m_baud = wrap && (m_os == 15);
      if (en) begin
        if (wrap) begin
          m_acc = (m_acc + m_frac) % 16;
          m_os = (m_os + 1) % 16;
          m_q = 0;
        end else begin
          m_q++;
        end
      end
      if (m_pend && (!en || wrap)) begin
        m_int = m_sint; m_frac = m_sfrac; m_pend = 0;
      end
      if (div_load && div_int >= 2) begin
        m_sint = div_int; m_sfrac = div_frac; m_pend = 1;
      end
    end
  endtask

  task automatic step(bit r, bit e, bit l, int di, int df);
    @(negedge clk);
    reset_n = r; en = e; div_load = l;
    div_int = di[15:0]; div_frac = df[3:0];
    @(posedge clk);
    model_edge();
    #1;
    chk("q_out", q_out, m_q);
    chk("os_cnt", os_cnt, m_os);
    chk("sample_tick", sample_tick, m_tick);
    chk("baud_tick", baud_tick, m_baud);
    chk("div_err", div_err, m_err);
    chk("div_pending", div_pending, m_pend);
  endtask

  task automatic wait_tick(int lim, output int n);
    bit hit = 0;
    n = 0;
    while (!hit && n < lim) begin
      step(1, 1, 0, 0, 0);
      n++;
      hit = sample_tick;
    end
    if (!hit) chk("tick_timeout", 0, 1);
  endtask

  task automatic wait_baud(int lim, output int n);
    bit hit = 0;
    n = 0;
    while (!hit && n < lim) begin
      step(1, 1, 0, 0, 0);
      n++;
      hit = baud_tick;
    end
    if (!hit) chk("baud_timeout", 0, 1);
  endtask

  task automatic run_until(int q, int os, int lim);
    int n = 0;
    while (!(q_out == q[15:0] && (os < 0 || os_cnt == os[3:0])) && n < lim) begin
      step(1, 1, 0, 0, 0);
      n++;
    end
    if (n >= lim) chk("seek_timeout", 0, 1);
  endtask

  initial begin
    int n, tk, bd;
    repeat (3) step(0, 0, 0, 0, 0);
    chk("rst_q", q_out, 0);
    chk("rst_tick", sample_tick, 0);

    // integer divide
    wait_tick(50, n);
    chk("first_tick_gap", n, 10);
    wait_tick(50, n);
    chk("int_gap", n, 10);
    wait_baud(400, n);
    chk("first_baud_gap", n, 140);
    wait_baud(400, n);
    chk("baud_gap", n, 160);

    // freeze at q_out=5
    run_until(5, -1, 50);
    tk = 0;
    repeat (7) begin
      step(1, 0, 0, 0, 0);
      tk += sample_tick;
    end
    chk("freeze_q", q_out, 5);
    chk("freeze_ticks", tk, 0);
    wait_tick(50, n);
    chk("resume_gap", n, 5);

    // shadow load mid-period
    run_until(4, -1, 50);
    step(1, 1, 1, 6, 0);
    chk("shadow_pending", div_pending, 1);
    wait_tick(50, n);
    chk("shadow_cur_gap", n, 5);
    chk("shadow_cleared", div_pending, 0);
    wait_tick(50, n);
    chk("shadow_new_gap", n, 6);

    // illegal load
    step(1, 1, 1, 1, 0);
    chk("illegal_err", div_err, 1);
    chk("illegal_pend", div_pending, 0);
    step(1, 1, 0, 0, 0);
    chk("illegal_err_off", div_err, 0);
    wait_tick(50, n);
    wait_tick(50, n);
    chk("illegal_gap", n, 6);

    // fractional divide 10 + 8/16
    step(1, 1, 1, 10, 8);
    wait_tick(50, n);
    wait_tick(50, n);
    tk = 0; bd = 0;
    repeat (168) begin
      step(1, 1, 0, 0, 0);
      tk += sample_tick;
      bd += baud_tick;
    end
    chk("frac_ticks", tk, 16);
    chk("frac_bauds", bd, 1);

    // reset mid-operation after a load of 20
    step(1, 1, 1, 20, 0);
    wait_tick(50, n);
    run_until(7, 9, 3000);
    step(0, 1, 0, 0, 0);
    chk("midrst_q", q_out, 0);
    chk("midrst_os", os_cnt, 0);
    wait_tick(50, n);
    chk("midrst_gap", n, 10);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 200) != 0, ($urandom % 8) != 0,
           ($urandom % 20) == 0, $urandom_range(0, 14),
           $urandom % 16);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
Parametrised baud-rate tick generator for the UART datapath; successor to the fixed-modulus baud counter.
- Divisor is runtime-programmable, with an integer part and a fractional part; the fraction is handled by accumulator dithering.
- Produces a single-cycle oversample tick (sample_tick) for RX sampling and a baud tick (baud_tick) every OVERSAMPLE sample ticks for TX bit timing.
- Supports enable/freeze, a shadowed divisor load applied on a period boundary, and rejection of illegal divisors.

Parameters:
CNT_W, 16, width of the integer divisor and of the clock-divide counter
FRAC_W, 4, width of the fractional divisor (fraction in units of 1/2^FRAC_W clocks)
OVERSAMPLE, 16, sample ticks per baud tick (>= 2)
OS_W, 4, width of the oversample counter (must satisfy 2^OS_W >= OVERSAMPLE)
DEF_DIV_INT, 10, integer divisor after reset (>= 2)
DEF_DIV_FRAC, 0, fractional divisor after reset

Ports:
clk  input  1  system clock
reset_n  input  1  reset, synchronous, active-low
en  input  1  count enable; 0 freezes all state
div_int  input  CNT_W  integer divisor for the sample-tick period, in clocks
div_frac  input  FRAC_W  fractional divisor, in units of 1/2^FRAC_W clocks
div_load  input  1  single-cycle strobe that captures div_int/div_frac into the shadow registers
div_err  output  1  one-cycle pulse when a load is rejected
sample_tick  output  1  one-cycle oversample tick
baud_tick  output  1  one-cycle baud tick, coincident with a sample_tick
q_out  output  CNT_W  current clock-divide counter value
os_cnt  output  OS_W  current oversample counter value
div_pending  output  1  shadow divisor waiting to be applied

Behaviour:
Reset (reset_n=0 sampled at posedge clk):
- q_out=0, os_cnt=0, frac accumulator=0.
- sample_tick=0, baud_tick=0, div_err=0, div_pending=0.
- Active divisor = DEF_DIV_INT / DEF_DIV_FRAC; shadow divisor = the same.
- Reset asserted mid-period aborts the period; no tick is emitted in the reset cycle.

Period arithmetic:
- Effective period P = div_int_act + carry, where carry is the carry-out of (acc + div_frac_act) computed at FRAC_W+1 bits.
- acc is updated to the low FRAC_W bits of that sum at each period end.
- Mean period = div_int_act + div_frac_act/2^FRAC_W clocks.

Counting (en=1):
- q_out increments 0..P-1.
- In the cycle q_out==P-1: sample_tick=1 (registered, so visible for that cycle), q_out wraps to 0, acc updates, os_cnt increments.
- os_cnt wraps from OVERSAMPLE-1 to 0.
- baud_tick=1 in the same cycle as the sample_tick where os_cnt==OVERSAMPLE-1.
- First sample_tick after reset appears DEF_DIV_INT clocks after the reset release edge, i.e. on the DEF_DIV_INT-th enabled clock.

Enable:
- en=0 holds q_out, os_cnt and acc unchanged; sample_tick=0 and baud_tick=0.
- Resuming continues from the held count; there is no restart.

Divisor load:
- div_load=1 with div_int>=2: capture into shadow; div_pending=1.
- div_load=1 with div_int<2: ignore, pulse div_err for 1 cycle, leave shadow and div_pending unchanged.
- Shadow transfers to active on the cycle q_out wraps to 0; div_pending clears in that cycle.
- With en=0, a pending shadow is applied on the next clock; q_out, os_cnt and acc are not reset.
- A new load while a load is pending overwrites the shadow (last load wins).
- Load coincident with a period end: the new value goes to shadow and is applied at the following wrap. The current wrap uses the previous active value.
- The period immediately after a divisor change starts from the current acc; acc is not cleared.

Outputs:
- All outputs are registered.
- No combinational path from any input to any output.

Test Plan:
- Integer divide: reset, div_int=10, div_frac=0, en=1 -> sample_tick every 10 clocks, first on clock 10; baud_tick every 160 clocks, coincident with every 16th sample_tick.
- Fractional divide: load div_int=10, div_frac=8 -> periods alternate 10,11; exactly 16 sample_ticks (1 baud_tick) in every 168 clocks.
- Shadow load mid-period: at q_out=4 of a 10-clock period, load div_int=6 -> div_pending=1; current period still ends at q_out=9; next period is 6 clocks; div_pending clears at the wrap.
- Illegal load: div_load with div_int=1 -> div_err pulses 1 cycle; tick spacing stays unchanged; div_pending remains 0.
- Freeze: drop en for 7 clocks at q_out=5 -> q_out holds 5, no ticks; after en=1 the next sample_tick comes 5 clocks later (div 10).
- Reset mid-operation: reset_n=0 at q_out=7, os_cnt=9 after a prior load of 20 -> q_out=0, os_cnt=0, div restored to 10; after release the first sample_tick comes at clock 10.
